mvm_row_accum: RTL and testbench

- Sits directly downstream of the 8-lane dot-product pipeline in the matrix-vector engine.
- Sums consecutive partial dot products (one per 8-element chunk) into one full row result.
- Saturates each row result to the output width and buffers it in a small FIFO.
- Presents results on a valid/ready interface, with a row index and an early stall signal so the upstream issuer can throttle the 4-cycle, non-stallable dot pipeline.

---
 rtl/mvm_pkg.sv | 33 +++
 rtl/mvm_result_fifo.sv | 54 +++++
 rtl/mvm_row_accum.sv | 118 +++++++++++
 tb/tb_mvm_row_accum.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared widths, saturation helper and result entry type
// for the matrix-vector row accumulator.
package mvm_pkg;

  localparam int DEF_IWIDTH     = 32;
  localparam int DEF_OWIDTH     = 32;
  localparam int DEF_MAX_CHUNKS = 64;
  localparam int DEF_ROW_W      = 8;

  localparam int AW = DEF_IWIDTH + $clog2(DEF_MAX_CHUNKS);
  localparam int CW = $clog2(DEF_MAX_CHUNKS + 1);

  typedef struct packed {
    logic [DEF_OWIDTH-1:0] odata;
    logic [DEF_ROW_W-1:0]  orow;
  } result_t;

  function automatic logic [DEF_OWIDTH-1:0] sat_to_owidth(
    input logic signed [AW-1:0] a
  );
    logic signed [AW-1:0] smax;
    logic signed [AW-1:0] smin;
    smax = {{(AW-DEF_OWIDTH+1){1'b0}}, {(DEF_OWIDTH-1){1'b1}}};
    smin = {{(AW-DEF_OWIDTH+1){1'b1}}, {(DEF_OWIDTH-1){1'b0}}};
    if (a > smax)
      sat_to_owidth = smax[DEF_OWIDTH-1:0];
    else if (a < smin)
      sat_to_owidth = smin[DEF_OWIDTH-1:0];
    else
      sat_to_owidth = a[DEF_OWIDTH-1:0];
  endfunction

endpackage

// File: rtl/mvm_result_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible while not empty.
// A push into a full FIFO is taken only when a pop frees the slot.
module mvm_result_fifo #(
  parameter int  DEPTH = 8,
  parameter type entry_t = logic [7:0],
  localparam int PW   = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  entry_t          din,
  input  logic            pop,
  output entry_t          dout,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)
        count <= count + 1'b1;
      else if (do_pop & ~do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mvm_row_accum.sv
// Sums per-chunk partial dot products into saturated row results
// and queues them with their row index for the consumer.
module mvm_row_accum
  import mvm_pkg::*;
#(
  parameter int IWIDTH     = DEF_IWIDTH,
  parameter int OWIDTH     = DEF_OWIDTH,
  parameter int MAX_CHUNKS = DEF_MAX_CHUNKS,
  parameter int FIFO_DEPTH = 8,
  parameter int SLACK      = 5,
  parameter int ROW_W      = DEF_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     cfg_chunks,
  input  logic              ivalid,
  input  logic [IWIDTH-1:0] idata,
  output logic              ostall,
  output logic              ovalid,
  input  logic              oready,
  output logic [OWIDTH-1:0] odata,
  output logic [ROW_W-1:0]  orow,
  output logic              err_ovf
);

  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]        cnt, cnt_n;
  logic [CW-1:0]        len, len_n;
  logic signed [AW-1:0] acc, acc_n;
  logic [ROW_W-1:0]     row, row_n;
  logic                 err_n;

  logic                 idle;
  logic [CW-1:0]        len_in;
  logic [CW-1:0]        cur_len;
  logic [CW-1:0]        cnt_inc;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] acc_next;
  logic                 done;
  logic                 drop;

  result_t              fin;
  result_t              fout;
  logic                 ffull;
  logic                 fempty;
  logic [CNTW-1:0]      fcount;

  assign idle     = (cnt == '0);
  assign len_in   = (cfg_chunks == '0) ? CW'(1) :
                    (int'(cfg_chunks) > MAX_CHUNKS) ? CW'(MAX_CHUNKS) :
                    cfg_chunks;
  assign cur_len  = idle ? len_in : len;
  assign cnt_inc  = cnt + 1'b1;
  assign ext      = AW'($signed(idata));
  assign acc_next = idle ? ext : acc + ext;
  assign done     = ivalid & (cnt_inc == cur_len);
  // A completed row is lost only when no pop frees a full FIFO.
  assign drop     = done & ffull & ~(ovalid & oready);

  always_comb begin
    cnt_n = cnt;
    len_n = len;
    acc_n = acc;
    row_n = row;
    err_n = err_ovf;
    if (ivalid) begin
      acc_n = acc_next;
      len_n = cur_len;
      cnt_n = done ? '0 : cnt_inc;
      if (done) begin
        row_n = row + 1'b1;
        if (drop)
          err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      len     <= '0;
      acc     <= '0;
      row     <= '0;
      err_ovf <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      len     <= len_n;
      acc     <= acc_n;
      row     <= row_n;
      err_ovf <= err_n;
    end
  end

  assign fin.odata = sat_to_owidth(acc_next);
  assign fin.orow  = row;

  mvm_result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (result_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .din   (fin),
    .pop   (oready),
    .dout  (fout),
    .full  (ffull),
    .empty (fempty),
    .count (fcount)
  );

  assign ovalid = ~fempty;
  assign odata  = fout.odata;
  assign orow   = fout.orow;
  assign ostall = (FIFO_DEPTH - int'(fcount)) <= SLACK;

endmodule

// File: tb/tb_mvm_row_accum.sv
// Randomised and directed bench for mvm_row_accum against
// a queue-based model of row sums, saturation and FIFO capacity.
module tb_mvm_row_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  cfg_chunks;
  logic        ivalid;
  logic [31:0] idata;
  logic        ostall;
  logic        ovalid;
  logic        oready;
  logic [31:0] odata;
  logic [7:0]  orow;
  logic        err_ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int d;
    int r;
  } ent_t;

  ent_t   m_q[$];
  longint m_sum;
  int     m_cnt;
  int     m_len;
  int     m_row;
  bit     m_err;

  always #5 clk = ~clk;

  mvm_row_accum dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_chunks (cfg_chunks),
    .ivalid     (ivalid),
    .idata      (idata),
    .ostall     (ostall),
    .ovalid     (ovalid),
    .oready     (oready),
    .odata      (odata),
    .orow       (orow),
    .err_ovf    (err_ovf)
  );

  function automatic int clamp32(longint s);
    if (s > 64'sd2147483647)
      return 32'h7fffffff;
    if (s < -64'sd2147483648)
      return 32'h80000000;
    return int'(s);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_len = 0;
    m_row = 0;
    m_err = 0;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    ivalid = 1'b0;
    idata  = '0;
    oready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic drive_cycle(input bit v, input logic [31:0] d,
                             input bit rdy);
    bit pop;
    ent_t e;
    ivalid = v;
    idata  = d;
    oready = rdy;
    @(posedge clk);
    pop = rdy && (m_q.size() > 0);
    if (pop)
      void'(m_q.pop_front());
    if (v) begin
      if (m_cnt == 0) begin
        m_len = (cfg_chunks == 0) ? 1 :
                (cfg_chunks > 64) ? 64 : int'(cfg_chunks);
        m_sum = 0;
      end
      m_sum += longint'($signed(d));
      m_cnt++;
      if (m_cnt == m_len) begin
        e.d = clamp32(m_sum);
        e.r = m_row;
        if (m_q.size() < 8)
          m_q.push_back(e);
        else
          m_err = 1;
        m_row = (m_row + 1) % 256;
        m_cnt = 0;
      end
    end
    #1;
    ivalid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({ovalid, ostall, err_ovf} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags got %b want 000",
               {ovalid, ostall, err_ovf});
    end
    n_checks++;
    if (odata !== 32'd0 || orow !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_data got %h/%0d want 0/0", odata, orow);
    end
  endtask

  task automatic test_len1();
    int vals [3] = '{5, -3, 7};
    apply_reset();
    cfg_chunks = 7'd1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 32'(vals[i]), 1'b1);
      n_checks++;
      if (ovalid !== 1'b1 || odata !== 32'(vals[i]) || orow !== 8'(i)) begin
        n_errors++;
        $display("FAIL len1_row%0d got v=%b d=%0d r=%0d want 1/%0d/%0d",
                 i, ovalid, $signed(odata), orow, vals[i], i);
      end
    end
  endtask

  task automatic test_gaps();
    int vals [4] = '{10, 20, -5, 100};
    apply_reset();
    cfg_chunks = 7'd4;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 32'(vals[i]), 1'b0);
      if (i < 3) begin
        repeat (2) drive_cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (ovalid !== 1'b0) begin
          n_errors++;
          $display("FAIL gaps_early_valid after %0d got %b want 0",
                   i, ovalid);
        end
      end
    end
    n_checks++;
    if (ovalid !== 1'b1 || odata !== 32'd125 || orow !== 8'd0) begin
      n_errors++;
      $display("FAIL gaps_result got v=%b d=%0d r=%0d want 1/125/0",
               ovalid, $signed(odata), orow);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cfg_chunks = 7'd2;
    drive_cycle(1'b1, 32'h7fffffff, 1'b1);
    drive_cycle(1'b1, 32'h7fffffff, 1'b1);
    n_checks++;
    if (ovalid !== 1'b1 || odata !== 32'h7fffffff) begin
      n_errors++;
      $display("FAIL sat_pos got v=%b d=%h want 1/7fffffff",
               ovalid, odata);
    end
    drive_cycle(1'b1, 32'h80000000, 1'b1);
    drive_cycle(1'b1, 32'hffffffff, 1'b1);
    n_checks++;
    if (ovalid !== 1'b1 || odata !== 32'h80000000 || orow !== 8'd1) begin
      n_errors++;
      $display("FAIL sat_neg got v=%b d=%h r=%0d want 1/80000000/1",
               ovalid, odata, orow);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    cfg_chunks = 7'd1;
    for (int k = 1; k <= 9; k++) begin
      drive_cycle(1'b1, $urandom, 1'b0);
      n_checks++;
      if (ostall !== (k >= 3) || err_ovf !== (k == 9)) begin
        n_errors++;
        $display("FAIL ovf_push%0d got stall=%b err=%b want %b/%b",
                 k, ostall, err_ovf, (k >= 3), (k == 9));
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ovalid !== 1'b1 || orow !== 8'(i) ||
          m_q.size() == 0 || odata !== 32'(m_q[0].d)) begin
        n_errors++;
        $display("FAIL ovf_drain%0d got v=%b r=%0d d=%h want row %0d",
                 i, ovalid, orow, odata, i);
      end
      drive_cycle(1'b0, '0, 1'b1);
    end
    drive_cycle(1'b1, 32'd42, 1'b0);
    n_checks++;
    if (ovalid !== 1'b1 || orow !== 8'd9 || odata !== 32'd42 ||
        err_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_next_row got v=%b r=%0d d=%0d err=%b want 1/9/42/1",
               ovalid, orow, odata, err_ovf);
    end
  endtask

  task automatic test_full_push_pop();
    int pops;
    apply_reset();
    cfg_chunks = 7'd1;
    for (int k = 0; k < 8; k++)
      drive_cycle(1'b1, 32'(k + 100), 1'b0);
    drive_cycle(1'b1, 32'd108, 1'b1);
    n_checks++;
    if (err_ovf !== 1'b0 || ostall !== 1'b1 || orow !== 8'd1) begin
      n_errors++;
      $display("FAIL fullpp_state got err=%b stall=%b r=%0d want 0/1/1",
               err_ovf, ostall, orow);
    end
    pops = 0;
    for (int c = 0; c < 20 && ovalid; c++) begin
      n_checks++;
      if (orow !== 8'(pops + 1) || odata !== 32'(pops + 101)) begin
        n_errors++;
        $display("FAIL fullpp_drain%0d got r=%0d d=%0d want %0d/%0d",
                 pops, orow, odata, pops + 1, pops + 101);
      end
      drive_cycle(1'b0, '0, 1'b1);
      pops++;
    end
    n_checks++;
    if (pops != 8) begin
      n_errors++;
      $display("FAIL fullpp_count got %0d want 8", pops);
    end
  endtask

  task automatic test_reset_midrow();
    apply_reset();
    cfg_chunks = 7'd3;
    drive_cycle(1'b1, 32'd50, 1'b0);
    drive_cycle(1'b1, 32'd60, 1'b0);
    apply_reset();
    drive_cycle(1'b1, 32'd1, 1'b0);
    drive_cycle(1'b1, 32'd2, 1'b0);
    n_checks++;
    if (ovalid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrow_early got v=%b want 0", ovalid);
    end
    drive_cycle(1'b1, 32'd3, 1'b0);
    n_checks++;
    if (ovalid !== 1'b1 || odata !== 32'd6 || orow !== 8'd0) begin
      n_errors++;
      $display("FAIL midrow_result got v=%b d=%0d r=%0d want 1/6/0",
               ovalid, $signed(odata), orow);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0)
        cfg_chunks = 7'($urandom_range(0, 70));
      d = ($urandom_range(0, 3) == 0) ? $urandom
                                      : 32'($urandom_range(0, 200) - 100);
      drive_cycle($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) != 0);
      n_checks++;
      if (ovalid !== (m_q.size() > 0) ||
          ostall !== ((8 - m_q.size()) <= 5) || err_ovf !== m_err) begin
        n_errors++;
        $display("FAIL rand_flags c=%0d got v=%b s=%b e=%b want %b/%b/%b",
                 c, ovalid, ostall, err_ovf, (m_q.size() > 0),
                 ((8 - m_q.size()) <= 5), m_err);
      end
      if (m_q.size() > 0) begin
        n_checks++;
        if (odata !== 32'(m_q[0].d) || orow !== 8'(m_q[0].r)) begin
          n_errors++;
          $display("FAIL rand_head c=%0d got %h/%0d want %h/%0d",
                   c, odata, orow, 32'(m_q[0].d), m_q[0].r);
        end
      end
    end
  endtask

  initial begin
    cfg_chunks = 7'd1;
    test_reset();
    test_len1();
    test_gaps();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_reset_midrow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
